// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div units: state encoding and width constants.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ZERO = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // One guard bit above the remainder so the trial sign is unambiguous.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             neg;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_i};
    assign neg     = trial[WIDTH+1];

    assign rem_o = neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div.sv
// Sequential signed divider: quotient to LO, remainder to HI after WIDTH restoring steps.
module div #(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    input  logic             DivCtrl,
    output logic             DivDone,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    import muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_active;

    // Magnitudes are taken as unsigned WIDTH-bit, so the most negative value maps onto itself exactly.
    assign abs_a = RegAOut[WIDTH-1] ? (~RegAOut + 1'b1) : RegAOut;
    assign abs_b = RegBOut[WIDTH-1] ? (~RegBOut + 1'b1) : RegBOut;

    assign div_active = (state_q == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (DivCtrl) begin
                    if (RegBOut != '0) begin
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        rem_d   = '0;
                        sq_d    = RegAOut[WIDTH-1] ^ RegBOut[WIDTH-1];
                        sr_d    = RegAOut[WIDTH-1];
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = ZERO;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                lo_d    = sq_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = sr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ZERO: begin
                done_d  = 1'b1;
                zero_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    assign DivDone = done_q;
    assign DivZero = zero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: signed cases, divide-by-zero, reset abort and ignored re-start.
module tb_div;

    logic        clk;
    logic        reset;
    logic [31:0] RegAOut;
    logic [31:0] RegBOut;
    logic        DivCtrl;
    logic        DivDone;
    logic        DivZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int compared   = 0;
    int mismatched = 0;

    div #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .RegAOut (RegAOut),
        .RegBOut (RegBOut),
        .DivCtrl (DivCtrl),
        .DivDone (DivDone),
        .DivZero (DivZero),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse DivCtrl across one rising edge (edge N); returns #1 after edge N.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        RegAOut = a;
        RegBOut = b;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
        RegAOut = $urandom;
        RegBOut = $urandom;
    endtask

    // Counts edges after edge N until DivDone is seen; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!DivDone && lat < 60);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        start(a, b);
        check({tag, " active"}, 64'(dut.div_active), 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " LO"}, 64'(LO), 64'(exp_lo));
        check({tag, " HI"}, 64'(HI), 64'(exp_hi));
        check({tag, " DivZero"}, 64'(DivZero), 64'd0);
        @(posedge clk);
        #1;
        check({tag, " done drop"}, 64'(DivDone), 64'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int cyc;
        int done_cyc;
        logic [31:0] cap_lo, cap_hi;

        reset   = 1'b1;
        RegAOut = '0;
        RegBOut = '0;
        DivCtrl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst HI", 64'(HI), 64'd0);
        check("rst LO", 64'(LO), 64'd0);
        check("rst DivDone", 64'(DivDone), 64'd0);
        check("rst DivZero", 64'(DivZero), 64'd0);
        reset = 1'b0;

        run_div("7/2",      32'd7,        32'd2,        32'h00000003, 32'h00000001);
        run_div("-7/2",     32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("7/-2",     32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
        run_div("min/-1",   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        run_div("min/1",    32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000);
        run_div("max/min",  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF);
        run_div("0/5",      32'd0,        32'd5,        32'h00000000, 32'h00000000);

        // Divide by zero must leave the previous result intact.
        run_div("9/4",      32'd9,        32'd4,        32'h00000002, 32'h00000001);
        start(32'd5, 32'd0);
        wait_done(lat);
        check("5/0 latency", 64'(lat), 64'd1);
        check("5/0 DivZero", 64'(DivZero), 64'd1);
        check("5/0 HI", 64'(HI), 64'd1);
        check("5/0 LO", 64'(LO), 64'd2);
        @(posedge clk);
        #1;
        check("5/0 done drop", 64'(DivDone), 64'd0);
        check("5/0 zero drop", 64'(DivZero), 64'd0);

        // Reset asserted just before edge N+10 abandons the operation.
        start(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort HI", 64'(HI), 64'd0);
        check("abort LO", 64'(LO), 64'd0);
        check("abort active", 64'(dut.div_active), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (DivDone) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        run_div("100/7",    32'd100,      32'd7,        32'h0000000E, 32'h00000002);

        // A second start pulse during RUN must be ignored.
        start(32'd20, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        RegAOut = 32'd50;
        RegBOut = 32'd5;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
        cyc      = 5;
        ndone    = 0;
        done_cyc = 0;
        cap_lo   = '0;
        cap_hi   = '0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (DivDone) begin
                ndone++;
                done_cyc = cyc;
                cap_lo   = LO;
                cap_hi   = HI;
            end
        end
        check("repulse count", 64'(ndone), 64'd1);
        check("repulse latency", 64'(done_cyc), 64'd33);
        check("repulse LO", 64'(cap_lo), 64'd6);
        check("repulse HI", 64'(cap_hi), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential signed 32-bit divider: the inverse of the `mult` unit, sharing its operand/result interface.
- Consumes `RegAOut` (dividend) and `RegBOut` (divisor) on a one-cycle `DivCtrl` start pulse.
- Runs a restoring shift-subtract loop, then writes quotient to `LO` and remainder to `HI`, as MIPS `DIV` does.
- Sits beside `mult` in the datapath; the control FSM stalls on `DivDone`, exactly as it does on `MultDone`.

Parameters:
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RegAOut`  in  WIDTH  dividend, two's complement.
- `RegBOut`  in  WIDTH  divisor, two's complement.
- `DivCtrl`  in  1  start pulse, sampled only in IDLE.
- `DivDone`  out  1  one-cycle completion pulse.
- `DivZero`  out  1  one-cycle divide-by-zero flag, coincident with `DivDone`.
- `HI`  out  WIDTH  remainder register.
- `LO`  out  WIDTH  quotient register.

Behaviour:
- Reset (async, any state):
  - FSM returns to IDLE.
  - `HI`=0, `LO`=0, `DivDone`=0, `DivZero`=0; counter and internal registers cleared.
- States: IDLE, RUN, DONE, ZERO.
- IDLE:
  - Edge N with `DivCtrl`=1 and `RegBOut`≠0:
    - Latch |A| into the quotient shift register and |B| into the divisor register.
    - Clear the WIDTH+1-bit partial remainder.
    - Record sign_q = A[31]^B[31] and sign_r = A[31].
    - Counter=0; go to RUN.
  - Edge N with `DivCtrl`=1 and `RegBOut`=0: go to ZERO.
  - `DivCtrl`=0: stay in IDLE.
- RUN: one restoring step per edge.
  - Shift {rem,quo} left by 1.
  - Trial = rem − divisor.
  - Trial non-negative: rem=trial, quo[0]=1; otherwise restore, quo[0]=0.
  - Counter increments; the step at counter=WIDTH−1 (edge N+WIDTH) moves to DONE.
- DONE, edge N+WIDTH+1:
  - `LO` = sign_q ? −quo : quo.
  - `HI` = sign_r ? −rem : rem.
  - `DivDone`=1 for exactly this cycle; return to IDLE.
  - Total latency: result visible after edge N+33 for `WIDTH`=32.
- ZERO, edge N+1:
  - `DivDone`=1 and `DivZero`=1 for one cycle.
  - `HI`/`LO` keep their previous values; return to IDLE.
- Handshake:
  - `DivCtrl` is ignored in RUN, DONE and ZERO; no queuing, no restart.
  - Operands are needed only at edge N and may change afterwards.
  - `HI`/`LO` hold their value between operations; they change only in DONE and on reset.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - |A|, |B| are WIDTH-bit unsigned, so |0x80000000| = 0x80000000 is exact.
  - 0x80000000 / 0xFFFFFFFF gives `LO`=0x80000000, `HI`=0 (wraps); no overflow flag.
  - Dividend 0 with non-zero divisor: runs the full loop; `LO`=0, `HI`=0.
- Reset mid-RUN: the operation is abandoned; no `DivDone`; outputs zero.
- Debug visibility: internal signal `div_active` is high in RUN. It is hierarchically readable by benches, as `mult_active` is in `mult`.

Decomposition:
- Shared package `muldiv_pkg`:
  - State encoding typedef (IDLE, RUN, DONE, ZERO).
  - `WIDTH` default constant.
  - Counter width `CNT_W` = $clog2(WIDTH)+1.
- One sub-module `div_step`: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside `div`.

Test Plan:
- 7 / 2: `DivCtrl` pulse at edge N → `DivDone` high in cycle after edge N+33, `LO`=0x00000003, `HI`=0x00000001, `DivZero`=0.
- −7 / 2 (0xFFFFFFF9 / 0x00000002) → `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF; 7 / −2 → `LO`=0xFFFFFFFD, `HI`=0x00000001.
- Preload `HI`/`LO` via 9 / 4 (`LO`=2, `HI`=1), then 5 / 0 → `DivDone`=`DivZero`=1 after edge N+1 for one cycle; `HI`=1, `LO`=2 unchanged.
- 0x80000000 / 0xFFFFFFFF → `LO`=0x80000000, `HI`=0; 0x80000000 / 0x00000001 → `LO`=0x80000000, `HI`=0.
- Start 1000 / 3, assert `reset` at edge N+10 for one cycle → no `DivDone`, `HI`=`LO`=0. Then 100 / 7 → `LO`=0x0000000E, `HI`=0x00000002.
- Re-pulse `DivCtrl` with 50 / 5 during RUN of 20 / 3 → ignored; result `LO`=6, `HI`=2; exactly one `DivDone` pulse.
